result_display: RTL and testbench
=================================

Name: result_display

Overview:
Output stage of the simple calculator. Consumes the 9-bit result from the operation units (Division, Sum, Subtraction, Multiplication), converts it to sign + 3 BCD digits with a sequential double-dabble, and drives a 4-digit multiplexed 7-segment display. It sits directly downstream of the operation units' result mux.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz per digit); minimum 2
CNT_W, 16, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
res_in  input  9  result to display, two's complement (-256..255)
res_load  input  1  capture strobe, sampled on rising clk edge
busy  output  1  conversion in progress; res_load is ignored while high
an  output  4  digit enables, active-low; an[0] = rightmost digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low, constant 1 (off)

Behaviour:
- Reset (asynchronous, active-low): an=4'b1111, seg=7'b1111111, dp=1, busy=0. Digit registers = 0, sign = 0, refresh counter = 0, scan index = 0. The display therefore shows "   0" from the first refresh tick.
- Capture: res_load=1 with busy=0 at edge E0 does the following.
  - Latch sign = res_in[8].
  - Latch magnitude = res_in[8] ? -res_in : res_in as 9-bit unsigned (0..256; 9'h100 -> 256).
  - Clear the BCD shift register and load the iteration counter with 9.
  - busy=1 after E0.
- Conversion: one iteration per clock at edges E1..E9. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, mag} left by 1.
  - At E9 the hundreds/tens/units registers and the sign register update atomically, and busy=0.
  - busy is high for exactly 9 cycles, so the latency from load to displayed value is 9 cycles.
- During conversion the display keeps showing the previous value. There is no partial-value flicker.
- res_load while busy=1 is ignored, including on cycle E9. A new load is accepted from the cycle after busy falls.
- Refresh counter counts 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 it wraps to 0 and issues a one-cycle tick.
- Each tick increments the 2-bit scan index, wrapping 3->0. an and seg are registered and update on the same edge as the index.
- Scan index 0: units digit, an=1110. Never blanked.
- Scan index 1: tens digit, an=1101. Blank if hundreds=0 and tens=0.
- Scan index 2: hundreds digit, an=1011. Blank if hundreds=0.
- Scan index 3: sign, an=0111. Minus (seg=0111111) if negative; otherwise blank (1111111).
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Until the first tick after reset, an stays 1111.
- Reset mid-conversion aborts it: busy=0, digits=0, sign=0. The display falls back to "   0".
- Zero with the sign bit clear never shows a minus. -0 cannot occur in two's complement.

Test Plan:
- Reset with REFRESH_DIV=4 -> an=1111 and busy=0 during reset; after the first tick an=1110 and seg=1000000; the other three slots show seg=1111111.
- res_in=9'd123 with a 1-cycle res_load -> busy high exactly 9 cycles; then over one scan round slot0=0110000, slot1=0100100, slot2=1111001, slot3=1111111.
- res_in=9'h100 (-256) -> slot3=0111111, slot2=0100100 (2), slot1=0010010 (5), slot0=0000010 (6).
- res_in=9'd7 -> hundreds and tens blank, units=1111000. Then res_in=9'd105 -> tens shows 1000000 (a zero inside the number is not blanked).
- Load 9'd255, then pulse res_load with 9'd1 three cycles later -> second load ignored; final display is "255", and busy falls 9 cycles after the first load.
- Load 9'd99, assert rst_n=0 at iteration 4 -> busy=0 and an=1111 immediately (asynchronous); after release the display shows units "0" only.

Source files
------------

// File: rtl/result_display_if.sv
// Result/display bundle between the calculator's result mux and the display stage.
// The master drives the result and strobe; the slave returns busy and the display pins.
interface result_display_if;
    logic [8:0] res_in;
    logic       res_load;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output res_in, output res_load,
                    input  busy, input an, input seg, input dp);
    modport slave  (input  res_in, input res_load,
                    output busy, output an, output seg, output dp);
endinterface

// File: rtl/result_display.sv
// Signed 9-bit result -> sign + 3 BCD digits (sequential double-dabble),
// shown on a 4-digit multiplexed active-low 7-segment display.
//
// state  | meaning
// S_IDLE | waiting for res_load; displayed digits are stable
// S_CONV | double-dabble running, one iteration per clock for 9 clocks
module result_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    result_display_if.slave bus
);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t     state;
    logic       busy_r;
    logic [8:0] mag;
    logic [11:0] bcd;
    logic [3:0] iter;
    logic       sign_pend;

    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
    logic       sign;

    logic [CNT_W-1:0] rcnt;
    logic             tick;
    logic [1:0]       idx;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic [3:0]       an_sel;
    logic [6:0]       seg_sel;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_next;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        bcd_adj  = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
        bcd_next = {bcd_adj[10:0], mag[8]};
    end

    // Digits and sign are only written on the last iteration, so the
    // display never sees a half-converted value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            iter      <= '0;
            sign_pend <= 1'b0;
            hund      <= '0;
            tens      <= '0;
            units     <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.res_load) begin
                        sign_pend <= bus.res_in[8];
                        mag       <= bus.res_in[8] ? (~bus.res_in + 9'd1) : bus.res_in;
                        bcd       <= '0;
                        iter      <= 4'd9;
                        busy_r    <= 1'b1;
                        state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd  <= bcd_next;
                    mag  <= {mag[7:0], 1'b0};
                    iter <= iter - 4'd1;
                    if (iter == 4'd1) begin
                        hund   <= bcd_next[11:8];
                        tens   <= bcd_next[7:4];
                        units  <= bcd_next[3:0];
                        sign   <= sign_pend;
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tick = (rcnt == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        an_sel  = 4'b1111;
        seg_sel = SEG_BLANK;
        case (idx)
            2'd0: begin
                an_sel  = 4'b1110;
                seg_sel = digit_seg(units);
            end
            2'd1: begin
                an_sel  = 4'b1101;
                seg_sel = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_seg(tens);
            end
            2'd2: begin
                an_sel  = 4'b1011;
                seg_sel = (hund == 4'd0) ? SEG_BLANK : digit_seg(hund);
            end
            default: begin
                an_sel  = 4'b0111;
                seg_sel = sign ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    // The slot for the current index is latched on the tick that also
    // advances the index, so the first tick after reset shows the units.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            idx   <= '0;
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
        end else if (tick) begin
            rcnt  <= '0;
            idx   <= idx + 2'd1;
            an_r  <= an_sel;
            seg_r <= seg_sel;
        end else begin
            rcnt <= rcnt + CNT_W'(1);
        end
    end

    assign bus.busy = busy_r;
    assign bus.an   = an_r;
    assign bus.seg  = seg_r;
    assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: directed plan cases plus random results, checked
// against an arithmetic model of what each display slot must show.
module tb_result_display;
    localparam int DIV = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] DIGITS [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                          7'b0110000, 7'b0011001, 7'b0010010,
                                          7'b0000010, 7'b1111000, 7'b0000000,
                                          7'b0010000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_display_if bus_i ();

    result_display #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [6:0] seen [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ref_seg(input int slot, input logic [8:0] r);
        int v, a, h, t, u;
        v = int'($signed(r));
        a = (v < 0) ? -v : v;
        h = a / 100;
        t = (a / 10) % 10;
        u = a % 10;
        case (slot)
            0: return DIGITS[u];
            1: return (h == 0 && t == 0) ? BLANK : DIGITS[t];
            2: return (h == 0) ? BLANK : DIGITS[h];
            default: return (v < 0) ? MINUS : BLANK;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [8:0] v);
        bus_i.res_in   = v;
        bus_i.res_load = 1'b1;
        cyc();
        bus_i.res_load = 1'b0;
    endtask

    task automatic wait_busy(input string tag, input int start);
        int n;
        n = start;
        while (bus_i.busy && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_busy_len"}, 32'(n), 32'd9);
    endtask

    task automatic check_display(input logic [8:0] r, input string tag);
        repeat (2 * DIV + 2) cyc();
        for (int s = 0; s < 4; s++) seen[s] = 7'bx;
        repeat (6 * DIV) begin
            case (bus_i.an)
                4'b1110: seen[0] = bus_i.seg;
                4'b1101: seen[1] = bus_i.seg;
                4'b1011: seen[2] = bus_i.seg;
                4'b0111: seen[3] = bus_i.seg;
                default: chk({tag, "_an_valid"}, 32'(bus_i.an), 32'hE);
            endcase
            cyc();
        end
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s_slot%0d", tag, s), 32'(seen[s]), 32'(ref_seg(s, r)));
    endtask

    task automatic load_and_check(input logic [8:0] r, input string tag);
        do_load(r);
        chk({tag, "_busy_rise"}, 32'(bus_i.busy), 32'd1);
        wait_busy(tag, 0);
        check_display(r, tag);
    endtask

    initial begin
        int n;
        logic [8:0] r;
        bus_i.res_in   = '0;
        bus_i.res_load = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_an", 32'(bus_i.an), 32'hF);
        chk("rst_seg", 32'(bus_i.seg), 32'(BLANK));
        chk("rst_busy", 32'(bus_i.busy), 32'd0);
        chk("rst_dp", 32'(bus_i.dp), 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (bus_i.an == 4'hF && n < 20) begin
            cyc();
            n++;
        end
        chk("first_tick_lat", 32'(n), 32'(DIV));
        chk("first_tick_an", 32'(bus_i.an), 32'hE);
        chk("first_tick_seg", 32'(bus_i.seg), 32'(DIGITS[0]));
        check_display(9'd0, "reset_zero");

        load_and_check(9'd123, "d123");
        load_and_check(9'h100, "m256");
        load_and_check(9'd7, "d7");
        load_and_check(9'd105, "d105");

        // second strobe while busy must be ignored
        do_load(9'd255);
        chk("ign_busy_rise", 32'(bus_i.busy), 32'd1);
        cyc();
        cyc();
        bus_i.res_in   = 9'd1;
        bus_i.res_load = 1'b1;
        cyc();
        bus_i.res_load = 1'b0;
        wait_busy("ign", 3);
        check_display(9'd255, "ign255");

        // reset in the middle of a conversion
        do_load(9'd99);
        repeat (4) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus_i.busy), 32'd0);
        chk("midrst_an", 32'(bus_i.an), 32'hF);
        #3;
        rst_n = 1'b1;
        chk("midrst_an_rel", 32'(bus_i.an), 32'hF);
        cyc();
        chk("midrst_busy_rel", 32'(bus_i.busy), 32'd0);
        check_display(9'd0, "midrst_zero");

        repeat (14) begin
            r = 9'($urandom_range(0, 511));
            load_and_check(r, $sformatf("rnd_%0h", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
